match_controller: RTL and testbench
===================================

Name: match_controller

Overview:
- Game-sequencing FSM for the ball-and-paddle design.
- Owns match flow (idle, serve countdown, play, pause, point delay, game over), keeps both scores, and selects paddle size.
- Gates the paddle controllers and the ball mover through its enable outputs.
- Sits between the button inputs, the ball/collision logic (miss pulses) and the paddle/ball datapaths.

Parameters:
- WIN_SCORE, 7: score that ends the match (1..15).
- SHRINK_SCORE, 4: once either score reaches this, bat_size goes to 1 (small paddle).
- SERVE_FRAMES, 60: frame_tick pulses spent in SERVE before PLAY (1..255).
- POINT_FRAMES, 90: frame_tick pulses spent in POINT before the next SERVE (1..255).

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-low; the sole reset.
- start  in  1  start/pause button, active-low, already debounced and synchronised.
- frame_tick  in  1  one-cycle pulse per video frame.
- miss_left  in  1  one-cycle pulse: ball passed the left paddle.
- miss_right  in  1  one-cycle pulse: ball passed the right paddle.
- state  out  3  current state: IDLE=0, SERVE=1, PLAY=2, PAUSE=3, POINT=4, OVER=5.
- ball_run  out  1  ball mover enable.
- paddle_en  out  1  paddle controllers enable.
- serve_dir  out  1  initial ball direction for the next serve: 0 = rightward, 1 = leftward.
- score_l  out  4  left player score.
- score_r  out  4  right player score.
- winner  out  2  0 = none, 1 = left, 2 = right.
- bat_size  out  1  0 = large paddle, 1 = small paddle; drives the paddle controllers' bat_size input.

Behaviour:
- All outputs are registered.
- Reset values: state=IDLE, ball_run=0, paddle_en=0, serve_dir=0, score_l=0, score_r=0, winner=0, bat_size=0, frame counter=0, start_q=1.
- Press detection: start_q is a registered copy of start; press = start_q & ~start (falling edge). Exactly one press per button push.
- Frame counter: 8 bits. Cleared on every state transition. Increments only on frame_tick, and only in SERVE and POINT.
- IDLE:
  - ball_run=0, paddle_en=0.
  - press -> SERVE; scores, winner and bat_size cleared; serve_dir=0.
- SERVE:
  - paddle_en=1, ball_run=0.
  - frame_tick while counter==SERVE_FRAMES-1 -> PLAY.
  - press is ignored.
- PLAY:
  - ball_run=1, paddle_en=1.
  - miss_left alone: score_r+1, serve_dir=1, -> POINT.
  - miss_right alone: score_l+1, serve_dir=0, -> POINT.
  - miss_left and miss_right in the same cycle: no score change, serve_dir unchanged, -> POINT.
  - Miss has priority over press in the same cycle.
  - press with no miss -> PAUSE.
- PAUSE:
  - ball_run=0, paddle_en=0.
  - press -> PLAY.
  - Misses and frame_tick are ignored.
- POINT:
  - ball_run=0, paddle_en=0.
  - On entry, if the incremented score == WIN_SCORE, the next state is OVER instead of POINT. winner is set in the same cycle as the score update.
  - Otherwise, frame_tick while counter==POINT_FRAMES-1 -> SERVE.
- OVER:
  - ball_run=0, paddle_en=0; scores and winner are held.
  - press -> SERVE with scores, winner and bat_size cleared and serve_dir=0.
- Miss pulses outside PLAY have no effect.
- Score width: 4 bits. Scores cannot exceed WIN_SCORE, so no wrap is possible.
- bat_size is set to 1 in the cycle after either score becomes >= SHRINK_SCORE. It stays 1 until a new match starts.
- Enables change in the same clock edge as the state change.
- Unused state encodings 6 and 7 return to IDLE on the next clock.
- Reset asserted mid-match forces all reset values immediately (asynchronous). Operation resumes in IDLE after release.

Decomposition:
- Shared package contains:
  - state encoding constants (IDLE..OVER);
  - winner codes;
  - serve_dir codes;
  - default WIN_SCORE, SHRINK_SCORE, SERVE_FRAMES and POINT_FRAMES.
- One natural sub-module, frame_timer: 8-bit counter with clear input, tick-qualified increment and a terminal-count compare. It is instantiated once and shared by SERVE and POINT.
- Press edge detection stays inline.

Test Plan:
1. Reset, release, start held high for 1000 cycles -> state=0, ball_run=0, paddle_en=0, scores 0.
2. Press start, then 60 frame_ticks -> state SERVE(1) immediately after the press, PLAY(2) on the cycle after the 60th tick; ball_run=1.
3. In PLAY, pulse miss_left -> score_r=1, serve_dir=1, state=4, ball_run=0; after 90 ticks state=1.
4. In PLAY, pulse miss_left and miss_right in the same cycle -> scores unchanged, state=4. In PAUSE, pulse miss_right -> no score change.
5. Drive score_l to 4 via miss_right pulses -> bat_size=1. Continue to 7 -> state=5, winner=1. Press -> state=1, scores 0, bat_size=0, winner=0.
6. In PLAY, press start -> PAUSE (3) with both enables 0; press again -> PLAY. Assert rst low mid-SERVE -> all outputs at reset values without waiting for a clock edge.

Source files
------------

// File: rtl/match_controller_pkg.sv
// Shared definitions for the match controller: state encoding, winner and
// serve-direction codes, and the default timing/score parameters.
package match_controller_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SERVE = 3'd1,
        ST_PLAY  = 3'd2,
        ST_PAUSE = 3'd3,
        ST_POINT = 3'd4,
        ST_OVER  = 3'd5
    } state_e;

    localparam logic [1:0] WINNER_NONE  = 2'd0;
    localparam logic [1:0] WINNER_LEFT  = 2'd1;
    localparam logic [1:0] WINNER_RIGHT = 2'd2;

    localparam logic SERVE_RIGHTWARD = 1'b0;
    localparam logic SERVE_LEFTWARD  = 1'b1;

    localparam int DEF_WIN_SCORE    = 7;
    localparam int DEF_SHRINK_SCORE = 4;
    localparam int DEF_SERVE_FRAMES = 60;
    localparam int DEF_POINT_FRAMES = 90;

endpackage

// File: rtl/match_controller_frame_timer.sv
// Frame counter shared by the SERVE and POINT phases: synchronous clear,
// tick-qualified increment and a terminal-count compare against term.
module frame_timer (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clr,
    input  logic       inc,
    input  logic [7:0] term,
    output logic       done
);

    logic [7:0] count_q;
    logic [7:0] count_d;

    // Next count: clear wins over increment.
    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (inc) begin
            count_d = count_q + 8'd1;
        end
    end

    // Counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign done = (count_q == term);

endmodule

// File: rtl/match_controller.sv
// Match sequencing FSM: owns match flow, both scores, serve direction,
// winner and paddle size, and gates the paddle and ball datapaths.
module match_controller #(
    parameter int WIN_SCORE    = match_controller_pkg::DEF_WIN_SCORE,
    parameter int SHRINK_SCORE = match_controller_pkg::DEF_SHRINK_SCORE,
    parameter int SERVE_FRAMES = match_controller_pkg::DEF_SERVE_FRAMES,
    parameter int POINT_FRAMES = match_controller_pkg::DEF_POINT_FRAMES
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       frame_tick,
    input  logic       miss_left,
    input  logic       miss_right,
    output logic [2:0] state,
    output logic       ball_run,
    output logic       paddle_en,
    output logic       serve_dir,
    output logic [3:0] score_l,
    output logic [3:0] score_r,
    output logic [1:0] winner,
    output logic       bat_size
);

    import match_controller_pkg::*;

    localparam logic [3:0] WIN_VAL    = 4'(WIN_SCORE);
    localparam logic [3:0] SHRINK_VAL = 4'(SHRINK_SCORE);
    localparam logic [7:0] SERVE_TERM = 8'(SERVE_FRAMES - 1);
    localparam logic [7:0] POINT_TERM = 8'(POINT_FRAMES - 1);

    state_e     state_q,     state_d;
    logic       ball_run_q,  ball_run_d;
    logic       paddle_en_q, paddle_en_d;
    logic       serve_dir_q, serve_dir_d;
    logic [3:0] score_l_q,   score_l_d;
    logic [3:0] score_r_q,   score_r_d;
    logic [1:0] winner_q,    winner_d;
    logic       bat_size_q,  bat_size_d;
    logic       start_q;

    logic       press;
    logic       shrink_hit;
    logic [3:0] score_l_inc;
    logic [3:0] score_r_inc;
    logic       tmr_clr;
    logic       tmr_inc;
    logic       tmr_done;
    logic [7:0] tmr_term;

    assign press       = start_q & ~start;
    assign shrink_hit  = (score_l_q >= SHRINK_VAL) || (score_r_q >= SHRINK_VAL);
    assign score_l_inc = score_l_q + 4'd1;
    assign score_r_inc = score_r_q + 4'd1;

    assign tmr_clr  = (state_d != state_q);
    assign tmr_inc  = frame_tick && ((state_q == ST_SERVE) || (state_q == ST_POINT));
    assign tmr_term = (state_q == ST_SERVE) ? SERVE_TERM : POINT_TERM;

    frame_timer u_frame_timer (
        .clk   (clk),
        .rst_n (rst),
        .clr   (tmr_clr),
        .inc   (tmr_inc),
        .term  (tmr_term),
        .done  (tmr_done)
    );

    // Next-state and next-output logic; enables follow the next state so they
    // change on the same edge as the state. A winning miss goes straight to
    // OVER rather than passing through POINT.
    always_comb begin
        state_d     = state_q;
        serve_dir_d = serve_dir_q;
        score_l_d   = score_l_q;
        score_r_d   = score_r_q;
        winner_d    = winner_q;
        bat_size_d  = bat_size_q | shrink_hit;

        case (state_q)
            ST_IDLE, ST_OVER: begin
                if (press) begin
                    state_d     = ST_SERVE;
                    score_l_d   = '0;
                    score_r_d   = '0;
                    winner_d    = WINNER_NONE;
                    bat_size_d  = 1'b0;
                    serve_dir_d = SERVE_RIGHTWARD;
                end
            end
            ST_SERVE: begin
                if (frame_tick && tmr_done) begin
                    state_d = ST_PLAY;
                end
            end
            ST_PLAY: begin
                if (miss_left && miss_right) begin
                    state_d = ST_POINT;
                end else if (miss_left) begin
                    score_r_d   = score_r_inc;
                    serve_dir_d = SERVE_LEFTWARD;
                    if (score_r_inc == WIN_VAL) begin
                        state_d  = ST_OVER;
                        winner_d = WINNER_RIGHT;
                    end else begin
                        state_d = ST_POINT;
                    end
                end else if (miss_right) begin
                    score_l_d   = score_l_inc;
                    serve_dir_d = SERVE_RIGHTWARD;
                    if (score_l_inc == WIN_VAL) begin
                        state_d  = ST_OVER;
                        winner_d = WINNER_LEFT;
                    end else begin
                        state_d = ST_POINT;
                    end
                end else if (press) begin
                    state_d = ST_PAUSE;
                end
            end
            ST_PAUSE: begin
                if (press) begin
                    state_d = ST_PLAY;
                end
            end
            ST_POINT: begin
                if (frame_tick && tmr_done) begin
                    state_d = ST_SERVE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        ball_run_d  = (state_d == ST_PLAY);
        paddle_en_d = (state_d == ST_SERVE) || (state_d == ST_PLAY);
    end

    // State, output and button-history registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            ball_run_q  <= 1'b0;
            paddle_en_q <= 1'b0;
            serve_dir_q <= SERVE_RIGHTWARD;
            score_l_q   <= '0;
            score_r_q   <= '0;
            winner_q    <= WINNER_NONE;
            bat_size_q  <= 1'b0;
            start_q     <= 1'b1;
        end else begin
            state_q     <= state_d;
            ball_run_q  <= ball_run_d;
            paddle_en_q <= paddle_en_d;
            serve_dir_q <= serve_dir_d;
            score_l_q   <= score_l_d;
            score_r_q   <= score_r_d;
            winner_q    <= winner_d;
            bat_size_q  <= bat_size_d;
            start_q     <= start;
        end
    end

    assign state     = state_q;
    assign ball_run  = ball_run_q;
    assign paddle_en = paddle_en_q;
    assign serve_dir = serve_dir_q;
    assign score_l   = score_l_q;
    assign score_r   = score_r_q;
    assign winner    = winner_q;
    assign bat_size  = bat_size_q;

endmodule

// File: tb/tb_match_controller.sv
// Directed bench for match_controller: walks a full match with
// hand-computed expectations, sampling outputs on the falling clock edge.
module tb_match_controller;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       frame_tick;
    logic       miss_left;
    logic       miss_right;
    logic [2:0] state;
    logic       ball_run;
    logic       paddle_en;
    logic       serve_dir;
    logic [3:0] score_l;
    logic [3:0] score_r;
    logic [1:0] winner;
    logic       bat_size;

    int unsigned n_checks;
    int unsigned n_errors;

    match_controller dut (
        .clk        (clk),
        .rst        (rst_n),
        .start      (start),
        .frame_tick (frame_tick),
        .miss_left  (miss_left),
        .miss_right (miss_right),
        .state      (state),
        .ball_run   (ball_run),
        .paddle_en  (paddle_en),
        .serve_dir  (serve_dir),
        .score_l    (score_l),
        .score_r    (score_r),
        .winner     (winner),
        .bat_size   (bat_size)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic press_btn();
        start = 1'b0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
    endtask

    task automatic send_ticks(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) begin
            frame_tick = 1'b1;
            @(negedge clk);
            frame_tick = 1'b0;
            @(negedge clk);
        end
    endtask

    task automatic pulse_miss(input logic l, input logic r);
        miss_left  = l;
        miss_right = r;
        @(negedge clk);
        miss_left  = 1'b0;
        miss_right = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_checks   = 0;
        n_errors   = 0;
        rst_n      = 1'b0;
        start      = 1'b1;
        frame_tick = 1'b0;
        miss_left  = 1'b0;
        miss_right = 1'b0;

        // 1: reset values, then idle with start held high
        #3;
        check("rst_state", state, 0);
        check("rst_ball_run", ball_run, 0);
        check("rst_paddle_en", paddle_en, 0);
        check("rst_bat_size", bat_size, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (1000) @(negedge clk);
        check("idle_state", state, 0);
        check("idle_ball_run", ball_run, 0);
        check("idle_paddle_en", paddle_en, 0);
        check("idle_score_l", score_l, 0);
        check("idle_score_r", score_r, 0);

        // 2: press -> SERVE; press during SERVE ignored; 60 ticks -> PLAY
        press_btn();
        check("serve_state", state, 1);
        check("serve_paddle_en", paddle_en, 1);
        check("serve_ball_run", ball_run, 0);
        press_btn();
        check("serve_press_ignored", state, 1);
        send_ticks(59);
        check("serve_59_ticks", state, 1);
        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
        check("play_after_60", state, 2);
        check("play_ball_run", ball_run, 1);
        check("play_paddle_en", paddle_en, 1);
        @(negedge clk);

        // 3: miss_left -> right scores, serve leftward, POINT for 90 ticks
        pulse_miss(1'b1, 1'b0);
        check("ml_score_r", score_r, 1);
        check("ml_score_l", score_l, 0);
        check("ml_serve_dir", serve_dir, 1);
        check("ml_state", state, 4);
        check("ml_ball_run", ball_run, 0);
        check("ml_paddle_en", paddle_en, 0);
        send_ticks(89);
        check("point_89_ticks", state, 4);
        send_ticks(1);
        check("point_to_serve", state, 1);

        // 4: simultaneous misses, then pause behaviour
        send_ticks(60);
        check("play_again", state, 2);
        pulse_miss(1'b1, 1'b1);
        check("both_state", state, 4);
        check("both_score_l", score_l, 0);
        check("both_score_r", score_r, 1);
        check("both_serve_dir", serve_dir, 1);
        send_ticks(90);
        send_ticks(60);
        check("play_3", state, 2);
        press_btn();
        check("pause_state", state, 3);
        check("pause_ball_run", ball_run, 0);
        check("pause_paddle_en", paddle_en, 0);
        pulse_miss(1'b0, 1'b1);
        check("pause_miss_score_l", score_l, 0);
        check("pause_miss_state", state, 3);
        send_ticks(3);
        check("pause_tick_state", state, 3);
        press_btn();
        check("unpause_state", state, 2);
        check("unpause_ball_run", ball_run, 1);

        // 5: left player wins via miss_right; first miss coincides with a press
        for (int unsigned k = 1; k <= 7; k++) begin
            if (k == 1) begin
                start      = 1'b0;
                miss_right = 1'b1;
                @(negedge clk);
                start      = 1'b1;
                miss_right = 1'b0;
                check("miss_beats_press", state, 4);
            end else begin
                pulse_miss(1'b0, 1'b1);
            end
            check($sformatf("mr%0d_score_l", k), score_l, k);
            check($sformatf("mr%0d_serve_dir", k), serve_dir, 0);
            if (k == 4) begin
                check("bat_not_yet", bat_size, 0);
                @(negedge clk);
                check("bat_small", bat_size, 1);
            end else if (k == 3) begin
                check("bat_large_at_3", bat_size, 0);
            end
            if (k < 7) begin
                send_ticks(90);
                send_ticks(60);
                check($sformatf("mr%0d_back_play", k), state, 2);
            end
        end
        check("over_state", state, 5);
        check("over_winner", winner, 1);
        check("over_score_r", score_r, 1);
        check("over_paddle_en", paddle_en, 0);
        pulse_miss(1'b1, 1'b0);
        send_ticks(2);
        check("over_hold_score_r", score_r, 1);
        check("over_hold_state", state, 5);
        press_btn();
        check("new_state", state, 1);
        check("new_score_l", score_l, 0);
        check("new_score_r", score_r, 0);
        check("new_winner", winner, 0);
        check("new_bat_size", bat_size, 0);
        check("new_serve_dir", serve_dir, 0);

        // 6: asynchronous reset mid-SERVE
        send_ticks(60);
        pulse_miss(1'b1, 1'b0);
        send_ticks(90);
        send_ticks(10);
        check("pre_rst_state", state, 1);
        check("pre_rst_serve_dir", serve_dir, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_state", state, 0);
        check("arst_paddle_en", paddle_en, 0);
        check("arst_score_r", score_r, 0);
        check("arst_serve_dir", serve_dir, 0);
        check("arst_winner", winner, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        check("post_rst_idle", state, 0);
        press_btn();
        check("post_rst_serve", state, 1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
